// File: rtl/frame_gen_pkg.sv
// Shared types for the frame timing generator: sequencer states and test-pattern selectors.
package frame_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VFRONT,
    ST_LINE,
    ST_HBLANK,
    ST_VBLANK
  } state_e;

  localparam logic [1:0] PAT_XRAMP = 2'd0;
  localparam logic [1:0] PAT_YRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FRAME = 2'd3;

endpackage

// File: rtl/frame_pattern_gen.sv
// Combinational test-pattern mapper: (x, y, frame count, pattern select) -> pixel value.
module frame_pattern_gen
  import frame_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 12
) (
  input  logic [15:0]       x,
  input  logic [15:0]       y,
  input  logic [7:0]        frame,
  input  logic [1:0]        pattern,
  output logic [DATA_W-1:0] pixel
);

  // Ramps truncate to DATA_W, so upper coordinate bits may go unused.
  logic unused_coord;
  assign unused_coord = ^{x, y};

  always_comb begin
    pixel = '0;
    case (pattern)
      PAT_XRAMP: pixel = x[DATA_W-1:0];
      PAT_YRAMP: pixel = y[DATA_W-1:0];
      PAT_CHECK: pixel = (x[4] ^ y[4]) ? '1 : '0;
      PAT_FRAME: pixel = DATA_W'(frame);
      default:   pixel = '0;
    endcase
  end

endmodule

// File: rtl/frame_timing_gen.sv
// Sensor timing emulator producing FVAL/LVAL/pixel frames.
// Define FRAMEGEN_PATTERN_EN to compile in the test-pattern generator; otherwise oDATA is held at 0.
module frame_timing_gen
  import frame_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 16,
  parameter int unsigned V_BLANK  = 1000,
  parameter int unsigned DATA_W   = 12
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEN,
  input  logic [1:0]        iPattern,
  output logic              oFVAL,
  output logic              oLVAL,
  output logic [DATA_W-1:0] oDATA,
  output logic              oFrame_Start,
  output logic [7:0]        oFrame_Cnt
);

  localparam logic [15:0] HA_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] VA_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VF_LAST = 16'(V_FRONT - 1);
  localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

  state_e      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] y, y_nxt;
  logic [7:0]  fcnt_nxt;
  logic        start_nxt;
  logic        fval_nxt;
  logic        lval_nxt;

  // cnt counts up from 0 in every state, so during LINE it is the x coordinate.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    y_nxt     = y;
    fcnt_nxt  = oFrame_Cnt;
    start_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (iEN) begin
          state_nxt = ST_VFRONT;
          start_nxt = 1'b1;
        end
      end
      ST_VFRONT: begin
        if (cnt == VF_LAST) begin
          state_nxt = ST_LINE;
          cnt_nxt   = '0;
          y_nxt     = '0;
        end
      end
      ST_LINE: begin
        if (cnt == HA_LAST) begin
          state_nxt = ST_HBLANK;
          cnt_nxt   = '0;
        end
      end
      ST_HBLANK: begin
        if (cnt == HB_LAST) begin
          cnt_nxt = '0;
          if (y == VA_LAST) begin
            state_nxt = ST_VBLANK;
            fcnt_nxt  = oFrame_Cnt + 8'd1;
          end else begin
            state_nxt = ST_LINE;
            y_nxt     = y + 16'd1;
          end
        end
      end
      ST_VBLANK: begin
        if (cnt == VB_LAST) begin
          cnt_nxt = '0;
          if (iEN) begin
            state_nxt = ST_VFRONT;
            start_nxt = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    fval_nxt = (state_nxt == ST_VFRONT) || (state_nxt == ST_LINE) || (state_nxt == ST_HBLANK);
    lval_nxt = (state_nxt == ST_LINE);
  end

`ifdef FRAMEGEN_PATTERN_EN
  logic [1:0]        pat;
  logic [DATA_W-1:0] pixel;

  frame_pattern_gen #(.DATA_W(DATA_W)) u_pattern (
    .x       (cnt_nxt),
    .y       (y_nxt),
    .frame   (fcnt_nxt),
    .pattern (pat),
    .pixel   (pixel)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pat <= '0;
    end else if (start_nxt) begin
      pat <= iPattern;
    end
  end
`else
  logic unused_pattern;
  assign unused_pattern = ^iPattern;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      y            <= '0;
      oFrame_Cnt   <= '0;
      oFVAL        <= 1'b0;
      oLVAL        <= 1'b0;
      oDATA        <= '0;
      oFrame_Start <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      y            <= y_nxt;
      oFrame_Cnt   <= fcnt_nxt;
      oFVAL        <= fval_nxt;
      oLVAL        <= lval_nxt;
      oFrame_Start <= start_nxt;
`ifdef FRAMEGEN_PATTERN_EN
      oDATA        <= lval_nxt ? pixel : '0;
`else
      oDATA        <= '0;
`endif
    end
  end

endmodule

// File: doc/frame_timing_gen.md
# frame_timing_gen

Camera-sensor timing emulator: generates the FVAL/LVAL/pixel-data stream that the capture side of the image-processing unit consumes. It produces whole frames with configurable active and blanking geometry, plus an optional built-in test pattern. It drives the capture path in simulation and on-board bring-up in place of the physical sensor, and it is the transmitting end of the same FVAL/LVAL interface the frame capture logic receives.

## Interface
- H_ACTIVE, 640, pixels per line (LVAL high cycles); 1..65535
- H_BLANK, 160, LVAL-low cycles after every line, inside FVAL; 1..65535
- V_ACTIVE, 480, lines per frame; 1..65535
- V_FRONT, 16, FVAL-high/LVAL-low cycles before first line; 1..65535
- V_BLANK, 1000, FVAL-low cycles between frames; 1..65535
- DATA_W, 12, pixel width; 8..16
- iCLK  in  1  clock
- iRST  in  1  synchronous reset, active-high
- iEN  in  1  level; frames generated while high
- iPattern  in  2  test pattern select (0 x-ramp, 1 y-ramp, 2 checker, 3 frame number)
- oFVAL  out  1  frame valid
- oLVAL  out  1  line valid
- oDATA  out  DATA_W  pixel data, valid when oLVAL=1
- oFrame_Start  out  1  one-cycle pulse coincident with first oFVAL=1 cycle
- oFrame_Cnt  out  8  completed-frame count

## Operation
- States: IDLE, VFRONT, LINE, HBLANK, VBLANK.
- IDLE: all outputs low. iEN=1 sampled → VFRONT, latch iPattern into pattern register, oFrame_Start=1.
- VFRONT: oFVAL=1, oLVAL=0, V_FRONT cycles → LINE, x=0, y=0.
- LINE: oFVAL=1, oLVAL=1, H_ACTIVE cycles, x increments 0..H_ACTIVE-1 → HBLANK.
- HBLANK: oFVAL=1, oLVAL=0, H_BLANK cycles; then y==V_ACTIVE-1 → VBLANK, else y+1 → LINE.
- VBLANK: oFVAL=0, V_BLANK cycles; oFrame_Cnt increments on entry (8-bit, 255→0). At end: iEN=1 → VFRONT (new frame, oFrame_Start, iPattern re-latched), else IDLE.
- iEN is examined only in IDLE and at the end of VBLANK; dropping iEN mid-frame completes the frame plus VBLANK.
- iPattern changes mid-frame have no effect until the next frame start.
- oDATA = 0 whenever oLVAL=0.
- Patterns (truncate to DATA_W): x-ramp = x; y-ramp = y; checker = all-ones if x[4]^y[4] else 0; frame number = oFrame_Cnt zero-extended.
- Counters 16 bits; cycle counter reloads on every state change.

## Timing
- All outputs registered; reset values: oFVAL=0, oLVAL=0, oDATA=0, oFrame_Start=0, oFrame_Cnt=0, state IDLE.
- iEN sampled high at edge k in IDLE → oFVAL=1 and oFrame_Start=1 during cycle after edge k.
- oFVAL high per frame: V_FRONT + V_ACTIVE·(H_ACTIVE+H_BLANK) cycles; frame period under continuous iEN: that + V_BLANK.
- oDATA is aligned with oLVAL (same cycle, no extra latency).
- iRST mid-frame: next edge returns all outputs to reset values; no partial line/frame completion. Restart needs iEN high in IDLE.

## Configuration
- FRAMEGEN_PATTERN_EN defined: pattern logic compiled in; oDATA as above.
- Undefined: pattern logic and pattern register omitted; oDATA tied to 0; iPattern ignored. Timing unchanged.

## Structure
- Package frame_gen_pkg: state enum, pattern select constants (PAT_XRAMP=0, PAT_YRAMP=1, PAT_CHECK=2, PAT_FRAME=3).
- Sub-module frame_pattern_gen: maps (x, y, frame count, pattern) → pixel; instantiated only under FRAMEGEN_PATTERN_EN.

## Test plan
Params H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_FRONT=1, V_BLANK=5, DATA_W=12.
- Reset held, iEN=1 → all outputs 0; release → oFVAL rises next cycle with oFrame_Start=1 for exactly one cycle.
- iEN high one cycle → one frame: oFVAL high 19 cycles, three oLVAL bursts of 4 separated by 2, then 5 low, IDLE; oFrame_Cnt=1.
- iEN held high → oFVAL period 24 cycles; oFrame_Cnt 0,1,2 at each VBLANK entry; 300 frames → wrap 255→0.
- iPattern=0 → oDATA 0,1,2,3 every line; iPattern=1 → lines 0,1,2 constant; switch iPattern mid-frame → no change until next frame.
- iRST asserted during second line → next cycle all outputs 0, oFrame_Cnt=0; subsequent frame full length.
- FRAMEGEN_PATTERN_EN undefined, iPattern=0 → oDATA stays 0, timing identical.
